// File: rtl/demux4_router.sv
// demux4_router: 1-to-4 valid/ready demultiplexer with a DEPTH-entry FIFO per output channel.
// Latency 1 clk from input accept to out_valid; in_ready = !full[in_sel] (head-of-line on a full target).
// Optional DEMUX4_STATS_EN adds saturating 16-bit per-channel pop counters stat_cnt0..3.
module demux4_router #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
`ifdef DEMUX4_STATS_EN
  output logic [DATA_W-1:0] out_data3,
  output logic [15:0]       stat_cnt0,
  output logic [15:0]       stat_cnt1,
  output logic [15:0]       stat_cnt2,
  output logic [15:0]       stat_cnt3
`else
  output logic [DATA_W-1:0] out_data3
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [DATA_W-1:0] dat_t;

  ptr_t wr_ptr_q [4];
  ptr_t wr_ptr_d [4];
  ptr_t rd_ptr_q [4];
  ptr_t rd_ptr_d [4];
  cnt_t cnt_q    [4];
  cnt_t cnt_d    [4];
  dat_t mem_q    [4][DEPTH];
  dat_t mem_d    [4][DEPTH];
  dat_t head     [4];

  logic [3:0] full;
  logic [3:0] push;
  logic [3:0] pop;

  // Handshake decode: everything here comes from registered state plus in_sel.
  always_comb begin
    full      = '0;
    out_valid = '0;
    for (int i = 0; i < 4; i++) begin
      full[i]      = (cnt_q[i] == cnt_t'(DEPTH));
      out_valid[i] = (cnt_q[i] != '0);
    end
    in_ready = !full[in_sel];
    push     = '0;
    if (in_valid && in_ready) begin
      push[in_sel] = 1'b1;
    end
    pop = out_valid & out_ready;
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < 4; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_data;
        wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head[i] = out_valid[i] ? mem_q[i][rd_ptr_q[i]] : '0;
    end
  end

  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  assign out_data3 = head[3];

`ifdef DEMUX4_STATS_EN
  logic [15:0] stat_q [4];
  logic [15:0] stat_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stat_d[i] = stat_q[i];
      if (pop[i] && (stat_q[i] != 16'hFFFF)) begin
        stat_d[i] = stat_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt0 = stat_q[0];
  assign stat_cnt1 = stat_q[1];
  assign stat_cnt2 = stat_q[2];
  assign stat_cnt3 = stat_q[3];
`endif

`ifndef SYNTHESIS
  a_in_known: assert property (@(posedge clk) disable iff (!rst_n)
    in_valid |-> !$isunknown({in_sel, in_data}));

  a_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready) |=> in_valid);

  for (genvar g = 0; g < 4; g++) begin : g_pop_chk
    a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n)
      pop[g] |-> (cnt_q[g] != '0));
  end
`endif

endmodule

// File: tb/tb_demux4_router.sv
// Scoreboard bench for demux4_router: per-channel expected queues filled on accepted pushes, drained on pops.
module tb_demux4_router;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_sel = 2'd0;
  logic [DATA_W-1:0] in_data = '0;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready = 4'b0000;
  logic [DATA_W-1:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX4_STATS_EN
  logic [15:0]       stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3;
`endif

  always #5 clk = ~clk;

  demux4_router #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
`ifdef DEMUX4_STATS_EN
    .out_data3 (out_data3),
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1),
    .stat_cnt2 (stat_cnt2),
    .stat_cnt3 (stat_cnt3)
`else
    .out_data3 (out_data3)
`endif
  );

  logic [DATA_W-1:0] exp_q [4][$];
  logic [15:0]       pop_cnt [4];
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] data_of(input int i);
    case (i)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  // Called at posedge+1 with inputs already driven; checks, updates the model, advances one clock.
  task automatic tick();
    logic exp_rdy;
    #2;
    exp_rdy = (exp_q[in_sel].size() < DEPTH);
    check_eq("in_ready", in_ready, exp_rdy);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("out_valid%0d", i), out_valid[i], exp_q[i].size() != 0);
      if (exp_q[i].size() != 0)
        check_eq($sformatf("out_data%0d_head", i), data_of(i), exp_q[i][0]);
      else
        check_eq($sformatf("out_data%0d_idle", i), data_of(i), 0);
    end
    for (int i = 0; i < 4; i++) begin
      if (exp_q[i].size() != 0 && out_ready[i]) begin
        void'(exp_q[i].pop_front());
        if (pop_cnt[i] != 16'hFFFF) pop_cnt[i]++;
      end
    end
    if (in_valid && exp_rdy) exp_q[in_sel].push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [1:0] sel, input logic [DATA_W-1:0] dat);
    in_valid = vld;
    in_sel   = sel;
    in_data  = dat;
  endtask

`ifdef DEMUX4_STATS_EN
  task automatic check_stats(input string tag);
    check_eq({tag, "_stat0"}, stat_cnt0, pop_cnt[0]);
    check_eq({tag, "_stat1"}, stat_cnt1, pop_cnt[1]);
    check_eq({tag, "_stat2"}, stat_cnt2, pop_cnt[2]);
    check_eq({tag, "_stat3"}, stat_cnt3, pop_cnt[3]);
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) pop_cnt[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 4'b0000);
    check_eq("rst_data", {out_data0, out_data1, out_data2, out_data3}, 0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef DEMUX4_STATS_EN
    check_stats("rst");
`endif

    // 1: single beat to channel 2, one clock latency
    drive(1'b1, 2'd2, 8'hA5);
    tick();
    drive(1'b0, 2'd0, 8'h00);
    check_eq("t1_valid", out_valid, 4'b0100);
    check_eq("t1_data2", out_data2, 8'hA5);
    check_eq("t1_others", {out_data0, out_data1, out_data3}, 0);

    // 2: fill channel 1, observe backpressure, drain in order
    drive(1'b1, 2'd1, 8'h11); tick();
    drive(1'b1, 2'd1, 8'h22); tick();
    drive(1'b0, 2'd1, 8'h00);
    #1;
    check_eq("t2_full_rdy", in_ready, 1'b0);
    check_eq("t2_head", out_data1, 8'h11);
    #1;
    tick();
    out_ready = 4'b0010;
    tick();
    check_eq("t2_rdy_back", in_ready, 1'b1);
    check_eq("t2_second", out_data1, 8'h22);
    tick();
    out_ready = 4'b0000;
    tick();
    check_eq("t2_drained", out_valid[1], 1'b0);

    // 3: channel 0 full and stalled does not block channel 3
    drive(1'b1, 2'd0, 8'h01); tick();
    drive(1'b1, 2'd0, 8'h02); tick();
    drive(1'b1, 2'd3, 8'h3C);
    #1;
    check_eq("t3_rdy", in_ready, 1'b1);
    #1;
    tick();
    drive(1'b0, 2'd0, 8'h00);
    check_eq("t3_valid3", out_valid[3], 1'b1);
    check_eq("t3_data3", out_data3, 8'h3C);
    check_eq("t3_ch0_head", out_data0, 8'h01);
    tick();

    // 4: push and pop together on channel 2 holding one entry
    drive(1'b1, 2'd2, 8'hB4);
    out_ready = 4'b0100;
    tick();
    drive(1'b0, 2'd0, 8'h00);
    out_ready = 4'b0000;
    check_eq("t4_valid2", out_valid[2], 1'b1);
    check_eq("t4_head", out_data2, 8'hB4);
    tick();

    // 5: fill every channel, asynchronous reset mid-cycle
    drive(1'b1, 2'd1, 8'hC1); tick();
    drive(1'b1, 2'd2, 8'hC2); tick();
    drive(1'b1, 2'd3, 8'hC3); tick();
    drive(1'b0, 2'd0, 8'h00);
    check_eq("t5_all_valid", out_valid, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", out_valid, 4'b0000);
    check_eq("t5_rst_data", {out_data0, out_data1, out_data2, out_data3}, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      pop_cnt[i] = '0;
    end
`ifdef DEMUX4_STATS_EN
    check_stats("t5_rst");
`endif
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 2'd0, 8'h5A);
    tick();
    drive(1'b0, 2'd0, 8'h00);
    check_eq("t5_valid", out_valid, 4'b0001);
    check_eq("t5_data0", out_data0, 8'h5A);

    // 6: pop traffic for statistics, then a long saturating run on channel 1
    out_ready = 4'b0001;
    drive(1'b1, 2'd0, 8'h5B); tick();
    drive(1'b1, 2'd0, 8'h5C); tick();
    drive(1'b0, 2'd0, 8'h00); tick();
    out_ready = 4'b1000;
    drive(1'b1, 2'd3, 8'h3D); tick();
    drive(1'b0, 2'd0, 8'h00); tick();
    out_ready = 4'b0000;
    tick();
    check_eq("t6_pops0", pop_cnt[0], 16'd3);
    check_eq("t6_pops3", pop_cnt[3], 16'd1);
`ifdef DEMUX4_STATS_EN
    check_eq("t6_stat0", stat_cnt0, 16'd3);
    check_eq("t6_stat3", stat_cnt3, 16'd1);
    check_stats("t6");
    out_ready = 4'b0010;
    for (int n = 0; n < 65540; n++) begin
      drive(1'b1, 2'd1, n[7:0]);
      tick();
    end
    drive(1'b0, 2'd0, 8'h00);
    tick();
    tick();
    out_ready = 4'b0000;
    check_eq("t6_sat1", stat_cnt1, 16'hFFFF);
    check_stats("t6_sat");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
